// File: rtl/image_mem_server.sv
// image_mem_server: 64x64 image store, loaded from a raster pixel stream and
// read by the scaler over REN/ADDR. Define RD_STAT_EN for RD_CNT/LAST_ADDR.
module image_mem_server #(
  parameter int DW         = 8,
  parameter int IMG_W_LOG2 = 6,
  parameter int RD_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    RST_N,
  input  logic                    LOAD,
  input  logic                    I_VALID,
  input  logic [DW-1:0]           I_DATA,
  output logic                    READY,
  output logic                    BUSY,
  input  logic                    REN,
  input  logic [2*IMG_W_LOG2-1:0] ADDR,
  output logic [DW-1:0]           R_DATA,
  output logic                    RD_ERR
`ifdef RD_STAT_EN
  ,
  output logic [15:0]             RD_CNT,
  output logic [2*IMG_W_LOG2-1:0] LAST_ADDR
`endif
);

  localparam int AW    = 2 * IMG_W_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] CNT_LAST = '1;

  if (RD_LAT != 1) begin : g_bad_lat
    $error("image_mem_server: RD_LAT must be 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SERVE
  } state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic          re_q;
  logic [DW-1:0] mem [DEPTH];

  logic          wr_en;
  logic          done;
  logic          rd_req;
  logic [AW-1:0] wr_idx;

  // raster pixel k lands at {H,V} so reads index with ADDR unchanged
  assign wr_idx = {cnt[IMG_W_LOG2-1:0], cnt[AW-1:IMG_W_LOG2]};
  assign wr_en  = (state == S_LOAD) && !LOAD && I_VALID;
  assign done   = wr_en && (cnt == CNT_LAST);
  assign rd_req = (state == S_SERVE) && !REN;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= I_DATA;
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      cnt    <= '0;
      READY  <= 1'b0;
      BUSY   <= 1'b0;
      RD_ERR <= 1'b0;
      re_q   <= 1'b0;
      addr_q <= '0;
      R_DATA <= '0;
    end else begin
      re_q <= rd_req;
      if (rd_req) addr_q <= ADDR;
      if (re_q) R_DATA <= mem[addr_q];

      if (LOAD) RD_ERR <= 1'b0;
      else if (!REN && state != S_SERVE) RD_ERR <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (LOAD) begin
            state <= S_LOAD;
            cnt   <= '0;
            BUSY  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (LOAD) begin
            cnt <= '0;
          end else if (I_VALID) begin
            cnt <= cnt + 1'b1;
            if (done) begin
              state <= S_SERVE;
              READY <= 1'b1;
              BUSY  <= 1'b0;
            end
          end
        end
        S_SERVE: begin
          if (LOAD) begin
            state <= S_LOAD;
            cnt   <= '0;
            READY <= 1'b0;
            BUSY  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RD_STAT_EN
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      RD_CNT    <= '0;
      LAST_ADDR <= '0;
    end else if (done) begin
      RD_CNT <= '0;
    end else if (re_q) begin
      if (RD_CNT != 16'hFFFF) RD_CNT <= RD_CNT + 16'd1;
      LAST_ADDR <= addr_q;
    end
  end
`endif

endmodule

// File: tb/tb_image_mem_server.sv
// tb_image_mem_server: random loads/reads against an image-array model,
// read data checked by a queue-based monitor.
module tb_image_mem_server;

  logic        clk;
  logic        RST_N;
  logic        LOAD;
  logic        I_VALID;
  logic [7:0]  I_DATA;
  logic        READY;
  logic        BUSY;
  logic        REN;
  logic [11:0] ADDR;
  logic [7:0]  R_DATA;
  logic        RD_ERR;
`ifdef RD_STAT_EN
  logic [15:0] RD_CNT;
  logic [11:0] LAST_ADDR;
`endif

  image_mem_server dut (
    .clk       (clk),
    .RST_N     (RST_N),
    .LOAD      (LOAD),
    .I_VALID   (I_VALID),
    .I_DATA    (I_DATA),
    .READY     (READY),
    .BUSY      (BUSY),
    .REN       (REN),
    .ADDR      (ADDR),
    .R_DATA    (R_DATA),
`ifdef RD_STAT_EN
    .RD_CNT    (RD_CNT),
    .LAST_ADDR (LAST_ADDR),
`endif
    .RD_ERR    (RD_ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: img[row][col], row = V, col = H
  logic [7:0] img [64][64];
  logic       m_ready = 1'b0;
  logic       m_err   = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: a REN=0 sampled at edge t is answered after edge t+1
  initial begin
    logic [7:0] last;
    bit pend;
    last = 8'h00;
    pend = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!RST_N) begin
        pend = 1'b0;
        last = 8'h00;
      end else begin
        if (pend) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got read with empty queue at %0t",
                     $time);
          end else begin
            last = exp_q.pop_front();
            chk("rdata", 32'(R_DATA), 32'(last));
          end
        end else begin
          chk("rdata_hold", 32'(R_DATA), 32'(last));
        end
        pend = !REN;
      end
    end
  end

  task automatic issue_read(input logic [11:0] a);
    REN  = 1'b0;
    ADDR = a;
    if (m_ready) m_rdata = img[a[5:0]][a[11:6]];
    else m_err = 1'b1;
    exp_q.push_back(m_rdata);
  endtask

  task automatic rd(input logic [11:0] a);
    @(negedge clk);
    LOAD    = 1'b0;
    I_VALID = 1'($urandom);
    I_DATA  = 8'($urandom);
    issue_read(a);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      LOAD    = 1'b0;
      REN     = 1'b1;
      ADDR    = 12'($urandom);
      I_VALID = 1'($urandom);
      I_DATA  = 8'($urandom);
    end
  endtask

  task automatic rand_reads(input int n);
    for (int i = 0; i < n; i++) begin
      rd(12'($urandom));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);
    chk("rd_err_serve", 32'(RD_ERR), 32'(m_err));
  endtask

  task automatic load_image(input bit rnd, input bit toggle,
                            input int err_at, input int abort_at,
                            input int restart_at, input bit rd_first);
    int k;
    bit v;
    bit err_done;
    bit err_chk;
    bit restarted;
    k = 0;
    v = 1'b1;
    err_done = 1'b0;
    err_chk = 1'b0;
    restarted = 1'b0;
    @(negedge clk);
    LOAD    = 1'b1;
    I_VALID = 1'b0;
    REN     = 1'b1;
    if (rd_first) issue_read(12'($urandom));
    m_ready = 1'b0;
    m_err   = 1'b0;
    @(negedge clk);
    LOAD = 1'b0;
    REN  = 1'b1;
    chk("load_flags", 32'({READY, BUSY}), 32'h1);
    chk("rd_err_clr", 32'(RD_ERR), 32'h0);
    while (k < 4096) begin
      if (k == abort_at) return;
      REN = 1'b1;
      if (k == restart_at && !restarted) begin
        restarted = 1'b1;
        LOAD    = 1'b1;
        I_VALID = 1'b0;
        k = 0;
      end else begin
        LOAD    = 1'b0;
        I_VALID = v;
        I_DATA  = 8'($urandom);
        if (v) begin
          if (!rnd) I_DATA = 8'(k * 7);
          img[k / 64][k % 64] = I_DATA;
          k++;
        end
        if (toggle) v = !v;
      end
      if (k == err_at && !err_done) begin
        err_done = 1'b1;
        err_chk  = 1'b1;
        issue_read(12'($urandom));
      end
      @(negedge clk);
      if (err_chk) begin
        err_chk = 1'b0;
        chk("rd_err_set", 32'(RD_ERR), 32'h1);
      end
      if (k < 4096) chk("loading", 32'({READY, BUSY}), 32'h1);
    end
    LOAD    = 1'b0;
    I_VALID = 1'b0;
    REN     = 1'b1;
    chk("load_done", 32'({READY, BUSY}), 32'h2);
    m_ready = 1'b1;
  endtask

  initial begin
    RST_N   = 1'b0;
    LOAD    = 1'b0;
    I_VALID = 1'b0;
    I_DATA  = 8'h00;
    REN     = 1'b1;
    ADDR    = 12'h000;
    #12;
    chk("reset_flags", 32'({READY, BUSY, RD_ERR}), 32'h0);
    chk("reset_rdata", 32'(R_DATA), 32'h0);
    @(negedge clk);
    RST_N = 1'b1;

    // directed image: pixel k = k*7
    load_image(1'b0, 1'b0, -1, -1, -1, 1'b0);
    rd({6'd3, 6'd2});
    idle(3);
    chk("rd_h3_v2", 32'(R_DATA), 32'h95);
    rd(12'h000);
    rd(12'hFFF);
    rd(12'h040);
    idle(2);
    chk("rd_last_b2b", 32'(R_DATA), 32'h07);
    rand_reads(200);

    // reload from SERVE with a read in the LOAD cycle, valid toggling
    load_image(1'b1, 1'b1, 1000, -1, -1, 1'b1);
    rand_reads(100);

    // asynchronous reset mid-load
    load_image(1'b1, 1'b0, 500, 2000, -1, 1'b0);
    I_VALID = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_flags", 32'({READY, BUSY, RD_ERR}), 32'h0);
    chk("async_rst_rdata", 32'(R_DATA), 32'h0);
    m_ready = 1'b0;
    m_err   = 1'b0;
    m_rdata = 8'h00;
    @(negedge clk);
    RST_N = 1'b1;

    // read while idle is not serviced and flags an error
    rd(12'($urandom));
    idle(1);
    chk("rd_err_idle", 32'(RD_ERR), 32'h1);

    // fresh load with a mid-stream restart
    load_image(1'b1, 1'b0, -1, -1, 300, 1'b0);
`ifdef RD_STAT_EN
    chk("rd_cnt_zero", 32'(RD_CNT), 32'h0);
    for (int i = 0; i < 9; i++) rd(12'($urandom));
    rd(12'h5A5);
    idle(2);
    chk("rd_cnt_10", 32'(RD_CNT), 32'd10);
    chk("last_addr", 32'(LAST_ADDR), 32'h5A5);
`endif
    rand_reads(100);

    load_image(1'b1, 1'b0, -1, -1, -1, 1'b0);
`ifdef RD_STAT_EN
    chk("rd_cnt_reload", 32'(RD_CNT), 32'h0);
`endif
    rand_reads(50);
    idle(3);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
